// File: rtl/chess_pkg.sv
// Shared board geometry, move width and sequencer state encoding for the
// chess move-generation pipeline.
package chess_pkg;
   localparam int NUM_SQ  = 64;
   localparam int SQ_W    = 10;
   localparam int MOVE_W  = 16;
   localparam int BOARD_W = NUM_SQ * SQ_W;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      GEN,
      DRAIN,
      FLUSH
   } state_t;
endpackage

// File: rtl/move_fifo.sv
// Synchronous FIFO with flush; head is shown combinationally and reads as
// zero while empty so the consumer never sees stale entries.
module move_fifo
   import chess_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = MOVE_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/move_sequencer.sv
// Drives the board's load / generate / pop handshake for one position and
// streams the popped moves to the search core through a move FIFO.
module move_sequencer
   import chess_pkg::*;
#(
   parameter int GEN_CYCLES = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [BOARD_W-1:0] board_in,
   input  logic               turn_in,
   input  logic [MOVE_W-1:0]  best_move,
   input  logic [NUM_SQ-1:0]  stack_empty,
   output logic [BOARD_W-1:0] original_pieces,
   output logic               turn,
   output logic               new_original,
   output logic               collect_pieces,
   output logic               move_order,
   output logic [MOVE_W-1:0]  mv_data,
   output logic               mv_valid,
   input  logic               mv_ready,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   move_count
);
   localparam int GW = (GEN_CYCLES > 1) ? $clog2(GEN_CYCLES) : 1;
   localparam logic [GW-1:0]    GEN_LAST = GW'(GEN_CYCLES - 1);
   localparam logic [GW-1:0]    GEN_ONE  = GW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t                      state;
   state_t                      state_nxt;
   logic [GW-1:0]               gen_cnt;
   logic                        done_nxt;
   logic                        all_empty;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   assign all_empty = &stack_empty;
   assign busy      = (state != IDLE);
   assign mv_valid  = !fifo_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      new_original   = 1'b0;
      collect_pieces = 1'b0;
      move_order     = 1'b0;
      done_nxt       = 1'b0;
      unique case (state)
         IDLE:  if (start) state_nxt = LOAD;
         LOAD: begin
            new_original = 1'b1;
            state_nxt    = GEN;
         end
         GEN: begin
            collect_pieces = 1'b1;
            if (gen_cnt == '0) state_nxt = DRAIN;
         end
         DRAIN: begin
            move_order = !fifo_full && !all_empty;
            if (all_empty) state_nxt = FLUSH;
         end
         FLUSH: begin
            if (fifo_count == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // abort outranks every transition, including start and completion
      if (abort) begin
         state_nxt = IDLE;
         done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         original_pieces <= '0;
         turn            <= 1'b0;
         gen_cnt         <= '0;
         move_count      <= '0;
         done            <= 1'b0;
      end else begin
         done <= done_nxt;
         if (state == IDLE && start && !abort) begin
            original_pieces <= board_in;
            turn            <= turn_in;
            move_count      <= '0;
         end
         if (state == LOAD)                      gen_cnt <= GEN_LAST;
         else if (state == GEN && gen_cnt != '0) gen_cnt <= gen_cnt - GEN_ONE;
         if (move_order && !abort && move_count != '1)
            move_count <= move_count + CNT_ONE;
      end
   end

   move_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (MOVE_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (abort),
      .push      (move_order),
      .push_data (best_move),
      .pop       (mv_valid && mv_ready),
      .head      (mv_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );
endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: stub board with queued moves, a timeline-level
// reference model checked every cycle, and directed literal expectations.
module tb_move_sequencer;
   import chess_pkg::*;

   localparam int G     = 16;
   localparam int DEPTH = 16;
   localparam int CW    = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic               turn_in = 1'b0;
   logic               mv_ready = 1'b0;
   logic [BOARD_W-1:0] board_in = '0;
   logic [MOVE_W-1:0]  best_move;
   logic [NUM_SQ-1:0]  stack_empty;
   logic [BOARD_W-1:0] original_pieces;
   logic               turn, new_original, collect_pieces, move_order;
   logic [MOVE_W-1:0]  mv_data;
   logic               mv_valid, busy, done;
   logic [CW-1:0]      move_count;

   always #5 clk = ~clk;

   move_sequencer #(.GEN_CYCLES(G), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .board_in(board_in), .turn_in(turn_in), .best_move(best_move),
      .stack_empty(stack_empty), .original_pieces(original_pieces),
      .turn(turn), .new_original(new_original), .collect_pieces(collect_pieces),
      .move_order(move_order), .mv_data(mv_data), .mv_valid(mv_valid),
      .mv_ready(mv_ready), .busy(busy), .done(done), .move_count(move_count)
   );

   // Stub board: moves pop off in order on every edge the sequencer requests one
   logic [MOVE_W-1:0] bmem [512];
   int bnum = 0;
   int bbase = 0;
   int bpop = 0;
   int bidx;
   assign bidx        = bpop - bbase;
   assign best_move   = (bidx < bnum) ? bmem[bidx] : '0;
   assign stack_empty = (bidx < bnum) ? {{(NUM_SQ-1){1'b1}}, 1'b0} : '1;

   // Reference model: position timeline (t = cycles since start) and a move queue
   logic [MOVE_W-1:0]  mfifo[$];
   int                 t = 0;
   bit                 active = 0, flushing = 0, done_flag = 0;
   bit                 m_push, m_pop, m_fin;
   logic [CW-1:0]      mcount = '0;
   logic [BOARD_W-1:0] exp_orig = '0;
   logic               exp_turn = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mfifo.delete();
         active = 0; flushing = 0; done_flag = 0; t = 0;
         mcount = '0; exp_orig = '0; exp_turn = 1'b0;
      end else begin
         if (move_order) bpop <= bpop + 1;
         done_flag = 0;
         if (abort) begin
            active = 0; flushing = 0;
            mfifo.delete();
         end else if (!active) begin
            if (start) begin
               active = 1; t = 1; mcount = '0;
               exp_orig = board_in; exp_turn = turn_in;
            end
         end else begin
            m_push = !flushing && t >= G + 2 && bidx < bnum && mfifo.size() < DEPTH;
            m_pop  = mfifo.size() != 0 && mv_ready;
            m_fin  = flushing && mfifo.size() == 0;
            if (!flushing && t >= G + 2 && bidx >= bnum) flushing = 1;
            if (m_pop) void'(mfifo.pop_front());
            if (m_push) begin
               mfifo.push_back(best_move);
               if (mcount != '1) mcount = mcount + 1'b1;
            end
            if (m_fin) begin
               active = 0; flushing = 0; done_flag = 1;
            end
            t = t + 1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   int first_no, last_no, first_col, last_col, first_mo, last_mo, n_mo;
   int done_cnt, done_t;
   logic [CW-1:0] count_at_done;
   logic turn_at_done;
   bit valid_seen;
   logic [MOVE_W-1:0] got[$];

   task automatic chk(input string name, input logic [BOARD_W-1:0] act,
                      input logic [BOARD_W-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic expv);
      chk(name, BOARD_W'(act), BOARD_W'(expv));
   endtask

   task automatic chki(input string name, input int act, input int expv);
      chk(name, BOARD_W'(act), BOARD_W'(expv));
   endtask

   task automatic compare();
      logic e_mo;
      if (!rst) return;
      if (active && t == 1) begin
         first_no = -1; last_no = -1; first_col = -1; last_col = -1;
         first_mo = -1; last_mo = -1; n_mo = 0; done_cnt = 0; done_t = -1;
         count_at_done = '0; turn_at_done = 1'b0; valid_seen = 0;
         got.delete();
      end
      e_mo = active && !flushing && t >= G + 2 && bidx < bnum && mfifo.size() < DEPTH;
      chkb("new_original", new_original, active && t == 1);
      chkb("collect_pieces", collect_pieces, active && t >= 2 && t <= G + 1);
      chkb("move_order", move_order, e_mo);
      chkb("mv_valid", mv_valid, mfifo.size() != 0);
      if (mfifo.size() != 0) chk("mv_data", BOARD_W'(mv_data), BOARD_W'(mfifo[0]));
      chk("move_count", BOARD_W'(move_count), BOARD_W'(mcount));
      chkb("busy", busy, active);
      chkb("done", done, done_flag);
      chk("original_pieces", original_pieces, exp_orig);
      chkb("turn", turn, exp_turn);
      if (new_original) begin if (first_no < 0) first_no = t; last_no = t; end
      if (collect_pieces) begin if (first_col < 0) first_col = t; last_col = t; end
      if (move_order) begin if (first_mo < 0) first_mo = t; last_mo = t; n_mo++; end
      if (mv_valid) valid_seen = 1;
      if (mv_valid && mv_ready) got.push_back(mv_data);
      if (done) begin
         done_cnt++; done_t = t; count_at_done = move_count; turn_at_done = turn;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_board(input int n, input logic [MOVE_W-1:0] first);
      bnum  = n;
      bbase = bpop;
      for (int i = 0; i < n; i++) bmem[i] = first + MOVE_W'(i);
   endtask

   task automatic kick();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
   endtask

   task automatic run_done(input int budget, input string name);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL %s_timeout: no done within %0d cycles, expected done", name, budget);
      end
      step();
   endtask

   task automatic chk_seq(input string name, input int n, input logic [MOVE_W-1:0] first);
      chki({name, "_len"}, got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++)
         chk(name, BOARD_W'(got[i]), BOARD_W'(first + MOVE_W'(i)));
   endtask

   function automatic logic [BOARD_W-1:0] mk_board(input int seed);
      logic [BOARD_W-1:0] b;
      for (int k = 0; k < NUM_SQ; k++) b[k*SQ_W +: SQ_W] = SQ_W'(k * 7 + seed);
      return b;
   endfunction

   task automatic chk_all_zero(input string name);
      chk({name, "_pieces"}, original_pieces, '0);
      chkb({name, "_turn"}, turn, 1'b0);
      chkb({name, "_new_original"}, new_original, 1'b0);
      chkb({name, "_collect"}, collect_pieces, 1'b0);
      chkb({name, "_move_order"}, move_order, 1'b0);
      chkb({name, "_mv_valid"}, mv_valid, 1'b0);
      chki({name, "_mv_data"}, int'(mv_data), 0);
      chkb({name, "_busy"}, busy, 1'b0);
      chkb({name, "_done"}, done, 1'b0);
      chki({name, "_move_count"}, int'(move_count), 0);
   endtask

   logic [BOARD_W-1:0] board_a;

   initial begin
      #3 rst = 1'b0;
      #1 chk_all_zero("reset");
      fork
         forever begin
            @(negedge clk);
            compare();
         end
      join_none
      @(posedge clk);
      #1 rst = 1'b1;
      step();

      // Five queued moves, consumer always ready
      load_board(5, 16'h1234);
      board_in = mk_board(3); turn_in = 1'b1; mv_ready = 1'b1;
      kick();
      run_done(100, "basic");
      chki("basic_first_no", first_no, 1);
      chki("basic_last_no", last_no, 1);
      chki("basic_first_col", first_col, 2);
      chki("basic_last_col", last_col, 17);
      chki("basic_first_mo", first_mo, 18);
      chki("basic_last_mo", last_mo, 22);
      chk_seq("basic_seq", 5, 16'h1234);
      chki("basic_count", int'(count_at_done), 5);
      chkb("basic_turn", turn_at_done, 1'b1);

      // Empty position
      load_board(0, 16'h0);
      kick();
      run_done(100, "empty");
      chki("empty_n_mo", n_mo, 0);
      chki("empty_count", int'(count_at_done), 0);
      chkb("empty_valid_seen", valid_seen, 1'b0);
      chki("empty_done_t", done_t, 20);

      // Forty moves against a stalled consumer
      load_board(40, 16'hA000);
      mv_ready = 1'b0;
      kick();
      repeat (40) step();
      chki("stall_n_mo", n_mo, 16);
      chkb("stall_mv_valid", mv_valid, 1'b1);
      chki("stall_mv_data", int'(mv_data), 32'hA000);
      chkb("stall_move_order", move_order, 1'b0);
      mv_ready = 1'b1;
      run_done(200, "stall");
      chk_seq("stall_seq", 40, 16'hA000);
      chki("stall_count", int'(count_at_done), 40);

      // start during GEN with a different position is ignored
      load_board(6, 16'h0B00);
      board_a = mk_board(11); board_in = board_a; turn_in = 1'b0;
      kick();
      repeat (3) step();
      board_in = mk_board(99); turn_in = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      chk("restart_pieces", original_pieces, board_a);
      chkb("restart_turn", turn, 1'b0);
      run_done(100, "restart");
      chki("restart_last_no", last_no, 1);
      chki("restart_count", int'(count_at_done), 6);

      // abort after three pops, then a fresh position
      load_board(10, 16'h5500);
      kick();
      begin
         int n = 0;
         while (got.size() < 3 && n < 60) begin step(); n++; end
      end
      chki("abort_pops", got.size(), 3);
      abort = 1'b1; step(); abort = 1'b0;
      chkb("abort_busy", busy, 1'b0);
      chkb("abort_mv_valid", mv_valid, 1'b0);
      repeat (30) step();
      chki("abort_no_done", done_cnt, 0);
      load_board(2, 16'h7700);
      kick();
      run_done(100, "after_abort");
      chki("after_abort_first_no", first_no, 1);
      chki("after_abort_first_mo", first_mo, 18);
      chk_seq("after_abort_seq", 2, 16'h7700);

      // move_count saturates
      load_board(300, 16'h4000);
      kick();
      run_done(400, "saturate");
      chki("saturate_count", int'(count_at_done), 255);
      chki("saturate_len", got.size(), 300);

      // asynchronous reset with seven moves buffered
      load_board(20, 16'hC000);
      mv_ready = 1'b0;
      kick();
      begin
         int n = 0;
         while (n_mo < 7 && n < 60) begin step(); n++; end
      end
      chki("midreset_n_mo", n_mo, 7);
      rst = 1'b0;
      #1 chk_all_zero("midreset");
      @(posedge clk);
      #1 rst = 1'b1;
      step();
      chkb("postreset_busy", busy, 1'b0);
      chkb("postreset_mv_valid", mv_valid, 1'b0);
      repeat (3) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
